// File: rtl/prog_clk_div.sv
// prog_clk_div -- multi-channel programmable clock divider.
//
// Produces NCH independent divided clocks from i_clk. Divisors are written at
// run time into a per-channel pending slot and take effect on that channel's
// next wrap, so the running period always completes (no runt pulses).
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_en       global count enable (low freezes counters and outputs)
//   i_sync     realign all active channels to phase 0 (overrides i_en)
//   i_div_wr   divisor write strobe
//   i_div_sel  target channel of the write
//   i_div_val  new divisor (1 -> 2, 0 -> channel disabled)
//   o_div_ack  one-cycle pulse the cycle after an accepted write
//   o_clk_out  registered divided clocks, one bit per channel
//   o_tick     registered wrap pulses (only when CLKDIV_TICK_EN is defined)
//
// Optional feature macro: CLKDIV_TICK_EN

module prog_clk_div_ch #(
  parameter int W       = 8,
  parameter int RST_DIV = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_sync,
  input  logic         i_wr,
  input  logic [W-1:0] i_val,
`ifdef CLKDIV_TICK_EN
  output logic         o_tick,
`endif
  output logic         o_clk_out
);
  logic [W-1:0] r_cnt, r_cur, r_pend;
  logic         r_pvld, r_clk;

  logic [W-1:0] w_cnt_nx, w_cur_nx, w_pend_nx, w_eff, w_inc;
  logic         w_clk_nx, w_pvld_nx, w_last;
  logic [W:0]   w_hi;

  assign w_eff  = r_pvld ? r_pend : r_cur;
  assign w_inc  = r_cnt + W'(1);
  assign w_last = (r_cnt == r_cur - W'(1));
  assign w_hi   = ({1'b0, r_cur} + (W+1)'(1)) >> 1;

  always_comb begin
    w_cnt_nx  = r_cnt;
    w_cur_nx  = r_cur;
    w_clk_nx  = r_clk;
    w_pvld_nx = r_pvld;
    w_pend_nx = r_pend;
    if (i_sync) begin
      if (w_eff != '0) begin
        w_cur_nx  = w_eff;
        w_pvld_nx = 1'b0;
        w_cnt_nx  = '0;
        w_clk_nx  = 1'b1;
      end else if (r_cur != '0) begin
        // pending zero applied by sync: channel switches off
        w_cur_nx  = '0;
        w_pvld_nx = 1'b0;
        w_cnt_nx  = '0;
        w_clk_nx  = 1'b0;
      end
    end else if (i_en) begin
      if (r_cur == '0) begin
        // disabled channel: apply immediately, restart as from reset
        if (r_pvld) begin
          w_cur_nx  = r_pend;
          w_pvld_nx = 1'b0;
          w_cnt_nx  = (r_pend != '0) ? r_pend - W'(1) : '0;
          w_clk_nx  = 1'b0;
        end
      end else if (w_last) begin
        w_cnt_nx = '0;
        w_clk_nx = 1'b1;
        if (r_pvld) begin
          w_cur_nx  = r_pend;
          w_pvld_nx = 1'b0;
          if (r_pend == '0) w_clk_nx = 1'b0;
        end
      end else begin
        w_cnt_nx = w_inc;
        w_clk_nx = ({1'b0, w_inc} < w_hi);
      end
    end
    // a write in the same cycle as an apply stays pending for the next one
    if (i_wr) begin
      w_pend_nx = i_val;
      w_pvld_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= W'(RST_DIV - 1);
      r_cur  <= W'(RST_DIV);
      r_pend <= '0;
      r_pvld <= 1'b0;
      r_clk  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nx;
      r_cur  <= w_cur_nx;
      r_pend <= w_pend_nx;
      r_pvld <= w_pvld_nx;
      r_clk  <= w_clk_nx;
    end
  end

  assign o_clk_out = r_clk;

`ifdef CLKDIV_TICK_EN
  // counter lands on 0 with output high only on a wrap or a sync edge
  logic r_tick;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tick <= 1'b0;
    else          r_tick <= (i_sync | i_en) & w_clk_nx & (w_cnt_nx == '0);
  end
  assign o_tick = r_tick;
`endif
endmodule

module prog_clk_div #(
  parameter int  NCH     = 4,
  parameter int  W       = 8,
  parameter int  RST_DIV = 2,
  localparam int SW      = $clog2(NCH)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic           i_sync,
  input  logic           i_div_wr,
  input  logic [SW-1:0]  i_div_sel,
  input  logic [W-1:0]   i_div_val,
  output logic           o_div_ack,
`ifdef CLKDIV_TICK_EN
  output logic [NCH-1:0] o_tick,
`endif
  output logic [NCH-1:0] o_clk_out
);
  logic         w_sel_ok;
  logic [W-1:0] w_val;
  logic         r_ack;

  if ((1 << SW) == NCH) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_chk
    assign w_sel_ok = (i_div_sel < SW'(NCH));
  end

  assign w_val = (i_div_val == W'(1)) ? W'(2) : i_div_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ack <= 1'b0;
    else          r_ack <= i_div_wr & w_sel_ok;
  end
  assign o_div_ack = r_ack;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    prog_clk_div_ch #(.W(W), .RST_DIV(RST_DIV)) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .i_sync    (i_sync),
      .i_wr      (i_div_wr & w_sel_ok & (i_div_sel == SW'(g))),
      .i_val     (w_val),
`ifdef CLKDIV_TICK_EN
      .o_tick    (o_tick[g]),
`endif
      .o_clk_out (o_clk_out[g])
    );
  end
endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Multi-channel programmable clock divider. It generates NCH independent divided clocks from one system clock, with divisors reloadable at run time. It replaces fixed power-of-two counter taps wherever a design needs arbitrary, odd or run-time-changed division ratios. Outputs are registered, glitch-free strobes/clocks for downstream logic running in the `clk` domain.

## Interface
- `NCH`, 4: number of output channels; ≥2.
- `W`, 8: divisor width in bits.
- `RST_DIV`, 2: divisor loaded into every channel at reset; 2..2^W-1.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global count enable; low freezes all counters and outputs.
- `sync`  in  1  realign all active channels to phase 0.
- `div_wr`  in  1  divisor write strobe, single cycle.
- `div_sel`  in  $clog2(NCH)  target channel of the write.
- `div_val`  in  W  new divisor.
- `div_ack`  out  1  one-cycle pulse, the cycle after an accepted write.
- `clk_out`  out  NCH  divided clocks, one bit per channel, registered.
- `tick`  out  NCH  terminal-count pulses; present only with `CLKDIV_TICK_EN`.

## Operation
- Per channel state: `cnt[W-1:0]`, `cur_div`, `pend_div`, `pend_vld`.
- Reset:
  - `cnt = RST_DIV-1`, `cur_div = RST_DIV`, `pend_vld = 0`.
  - `clk_out = 0`, `div_ack = 0`, `tick = 0`.
- Counting (en=1, `cur_div = N ≥ 2`):
  - `cnt_next = (cnt == N-1) ? 0 : cnt+1`.
  - `clk_out <= (cnt_next < hi)`, where `hi = (N+1)>>1`.
  - Period is N cycles: high for ceil(N/2) cycles, low for floor(N/2). Odd N gives the extra cycle to the high phase.
- Writes:
  - `div_wr` with `div_sel < NCH` stores `div_val` into `pend_div`, sets `pend_vld`, and pulses `div_ack` on the next cycle.
  - `div_sel ≥ NCH` is ignored; no ack.
  - Writes are accepted regardless of `en`.
  - A second write before the apply overwrites `pend_div`. Only the last value is applied.
- Apply (glitch-free):
  - The pending value becomes `cur_div` on the edge where `cnt` wraps to 0. The new period starts at that edge.
  - The currently running period always completes.
- Divisor values:
  - `div_val == 1` is clamped to 2.
  - `div_val == 0` disables the channel once applied: `clk_out` and `cnt` are held at 0.
  - A write to a disabled channel applies on the next cycle, not waiting for a wrap. The channel restarts as from reset with the new N (`cnt = N-1`, `clk_out = 0`), and its first rising edge comes on the following enabled edge.
- `sync` (priority over `en`):
  - Affects every channel with a nonzero divisor: any pending divisor is applied, then `cnt <= 0` and `clk_out <= 1`. All active channels rise together.
  - `div_wr` in the same cycle as `sync`: the sync applies the previously pending value. The new write becomes pending and applies at the next wrap.
- `en` low: `cnt`, `clk_out` and `cur_div` hold; `tick` is 0.

## Timing
- First `clk_out` rising edge: the first enabled `clk` edge after `rst_n` deasserts.
- `div_ack`: exactly 1 cycle after the `div_wr` edge.
- Write-to-effect latency: up to N cycles, bounded by the remaining period.
- `rst_n` asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronous).
  - Pending writes are lost.
  - Release is synchronous to the next edge.
- No combinational path from any input to any output.

## Configuration
- `CLKDIV_TICK_EN` defined:
  - The `tick` port exists.
  - `tick[i]` is high for one cycle on each edge where channel i wraps to 0 (coincident with the `clk_out` rise), including the sync edge.
  - `tick[i]` is never high while the channel is disabled or `en` = 0.
- `CLKDIV_TICK_EN` undefined: no `tick` port and no tick logic. All other behaviour is identical.

## Test plan
- Reset, then en=1, defaults (RST_DIV=2): every `clk_out` toggles each cycle. First rise on the 1st edge after reset release. `div_ack` = 0.
- Write ch1=5, ch2=16, ch3=1:
  - ch1 is high 3 cycles / low 2.
  - ch2 is high 8 / low 8.
  - ch3 behaves as N=2.
  - Each write gives a `div_ack` pulse the next cycle.
  - Each new divisor starts exactly at that channel's wrap.
- Mid-period rewrite on ch0 (N=8→3→6 before the wrap): only 6 is applied. The current period stays 8 cycles long, with no runt pulse.
- With channels at N=3,4,5,7, pulse `sync`: all rise on the same edge. With TICK_EN, all `tick` bits are 1 that cycle.
- en=0 for 5 cycles mid-period: outputs frozen, and the period resumes with the remaining count intact. Write 0 to ch2: ch2 goes low after its wrap. Write 4: ch2 restarts within 2 cycles.
- Assert `rst_n` mid-period with a pending write: outputs 0 immediately. After release, the channel runs at RST_DIV and the pending value is discarded.
